// File: rtl/sprite_compositor.sv
// sprite_compositor
//   Multi-sprite pixel compositor. For each pixel from the VGA counter, the
//   lowest-index enabled sprite that covers it supplies a texel address to an
//   external synchronous-read texture RAM. The returned texel is shown unless
//   it equals the colour key, in which case the background colour is shown.
//   Sprite registers are written over AXI4-Lite into a shadow set and copied
//   to the active set on the falling edge of vsync_in.
// Ports
//   clk, rst              : clock, asynchronous active-low reset
//   aw*/w*/b*             : AXI4-Lite write slave (awprot ignored)
//   pix_en, x, y          : pixel strobe and coordinate
//   visible, hsync_in, vsync_in : VGA counter timing
//   raddr / rtexel        : texture RAM address (combinational) / data (1-cycle latency)
//   red, green, blue      : pixel colour, 2 cycles after the pixel is presented
//   hsync, vsync          : syncs delayed to match the colour
module sprite_compositor #(
  parameter int SPRITE_COUNT   = 8,
  parameter int SPRITE_SIZE    = 64,
  parameter int TEXTURE_COUNT  = 4,
  parameter int COORD_WIDTH    = 10,
  parameter int COLOR_WIDTH    = 12,
  parameter logic [COLOR_WIDTH-1:0] TRANSPARENT = 12'hF0F,
  parameter int DATA_WIDTH     = 32,
  parameter int ADDR_WIDTH     = 24,
  parameter int STRB_WIDTH     = DATA_WIDTH / 8,
  parameter int TEX_ADDR_WIDTH = $clog2(TEXTURE_COUNT * SPRITE_SIZE * SPRITE_SIZE)
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic [ADDR_WIDTH-1:0]     awaddr,
  input  logic [2:0]                awprot,
  input  logic                      awvalid,
  output logic                      awready,
  input  logic [DATA_WIDTH-1:0]     wdata,
  input  logic [STRB_WIDTH-1:0]     wstrb,
  input  logic                      wvalid,
  output logic                      wready,
  output logic [1:0]                bresp,
  output logic                      bvalid,
  input  logic                      bready,
  input  logic                      pix_en,
  input  logic [COORD_WIDTH-1:0]    x,
  input  logic [COORD_WIDTH-1:0]    y,
  input  logic                      visible,
  input  logic                      hsync_in,
  input  logic                      vsync_in,
  output logic [TEX_ADDR_WIDTH-1:0] raddr,
  input  logic [COLOR_WIDTH-1:0]    rtexel,
  output logic [3:0]                red,
  output logic [3:0]                green,
  output logic [3:0]                blue,
  output logic                      hsync,
  output logic                      vsync
);

  localparam int SB   = $clog2(SPRITE_SIZE);
  localparam int CW1  = COORD_WIDTH + 1;
  localparam int IDXW = ADDR_WIDTH - 2;
  localparam int TAW  = TEX_ADDR_WIDTH;

  // ---------------------------------------------------------------- AXI write
  logic                  r_awready, r_wready, r_aw_held, r_w_held, r_bvalid;
  logic [1:0]            r_bresp;
  logic [IDXW-1:0]       r_idx;     // word index of the held address
  logic [DATA_WIDTH-1:0] r_wdata;
  logic [STRB_WIDTH-1:0] r_wstrb;

  logic                  w_aw_hs, w_w_hs, w_do_write;
  logic                  w_aw_held_nx, w_w_held_nx, w_bvalid_nx, w_in_range;
  logic [DATA_WIDTH-1:0] w_wmask;
  logic                  w_unused;

  assign w_unused = ^{awprot, awaddr[1:0]};

  always_comb begin
    // NOTE: every variable gets a default first so no path leaves it unassigned (no latch).
    w_wmask = '0;
    for (int b = 0; b < STRB_WIDTH; b++) w_wmask[8*b +: 8] = {8{r_wstrb[b]}};
    w_aw_hs      = awvalid && r_awready;
    w_w_hs       = wvalid && r_wready;
    w_do_write   = r_aw_held && r_w_held && !r_bvalid;
    w_aw_held_nx = w_do_write ? 1'b0 : (r_aw_held || w_aw_hs);
    w_w_held_nx  = w_do_write ? 1'b0 : (r_w_held || w_w_hs);
    w_bvalid_nx  = w_do_write ? 1'b1 : (r_bvalid && !bready);
    w_in_range   = (r_idx <= IDXW'(2 * SPRITE_COUNT));
  end

  // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_awready <= 1'b0;
      r_wready  <= 1'b0;
      r_aw_held <= 1'b0;
      r_w_held  <= 1'b0;
      r_bvalid  <= 1'b0;
      r_bresp   <= 2'b00;
      r_idx     <= '0;
      r_wdata   <= '0;
      r_wstrb   <= '0;
    end else begin
      r_aw_held <= w_aw_held_nx;
      r_w_held  <= w_w_held_nx;
      r_bvalid  <= w_bvalid_nx;
      // Ready reflects next-cycle state so it drops on the accepting edge.
      r_awready <= !w_aw_held_nx && !w_bvalid_nx;
      r_wready  <= !w_w_held_nx && !w_bvalid_nx;
      if (w_aw_hs) r_idx <= awaddr[ADDR_WIDTH-1:2];
      if (w_w_hs) begin
        r_wdata <= wdata;
        r_wstrb <= wstrb;
      end
      if (w_do_write) r_bresp <= w_in_range ? 2'b00 : 2'b10;
    end
  end

  assign awready = r_awready;
  assign wready  = r_wready;
  assign bvalid  = r_bvalid;
  assign bresp   = r_bresp;

  // ---------------------------------------------------------- shadow / active
  function automatic logic [DATA_WIDTH-1:0] merge(input logic [DATA_WIDTH-1:0] old_w,
                                                   input logic [DATA_WIDTH-1:0] new_w,
                                                   input logic [DATA_WIDTH-1:0] mask);
    return (old_w & ~mask) | (new_w & mask);
  endfunction

  logic [DATA_WIDTH-1:0]  r_sh_pos  [SPRITE_COUNT];
  logic [DATA_WIDTH-1:0]  r_sh_ctrl [SPRITE_COUNT];
  logic [DATA_WIDTH-1:0]  r_sh_bg;
  logic [COORD_WIDTH-1:0] r_act_x   [SPRITE_COUNT];
  logic [COORD_WIDTH-1:0] r_act_y   [SPRITE_COUNT];
  logic [7:0]             r_act_tex [SPRITE_COUNT];
  logic [SPRITE_COUNT-1:0] r_act_en;
  logic [COLOR_WIDTH-1:0] r_act_bg;
  logic                   r_vsync_d;
  logic                   w_commit;

  assign w_commit = r_vsync_d && !vsync_in;

  // NOTE: the register arrays are reset because a defined power-up state (all sprites off) is required.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int i = 0; i < SPRITE_COUNT; i++) begin
        r_sh_pos[i]  <= '0;
        r_sh_ctrl[i] <= '0;
      end
      r_sh_bg <= '0;
    end else if (w_do_write) begin
      for (int i = 0; i < SPRITE_COUNT; i++) begin
        if (r_idx == IDXW'(2 * i))     r_sh_pos[i]  <= merge(r_sh_pos[i],  r_wdata, w_wmask);
        if (r_idx == IDXW'(2 * i + 1)) r_sh_ctrl[i] <= merge(r_sh_ctrl[i], r_wdata, w_wmask);
      end
      if (r_idx == IDXW'(2 * SPRITE_COUNT)) r_sh_bg <= merge(r_sh_bg, r_wdata, w_wmask);
    end
  end

  // A write on the commit edge is not seen here: the copy reads the pre-edge shadow.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int i = 0; i < SPRITE_COUNT; i++) begin
        r_act_x[i]   <= '0;
        r_act_y[i]   <= '0;
        r_act_tex[i] <= '0;
      end
      r_act_en  <= '0;
      r_act_bg  <= '0;
      r_vsync_d <= 1'b1;
    end else begin
      r_vsync_d <= vsync_in;
      if (w_commit) begin
        for (int i = 0; i < SPRITE_COUNT; i++) begin
          r_act_x[i]   <= r_sh_pos[i][COORD_WIDTH-1:0];
          r_act_y[i]   <= r_sh_pos[i][16 +: COORD_WIDTH];
          r_act_tex[i] <= r_sh_ctrl[i][7:0];
          r_act_en[i]  <= r_sh_ctrl[i][31];
        end
        r_act_bg <= r_sh_bg[COLOR_WIDTH-1:0];
      end
    end
  end

  // ------------------------------------------------------- stage 1: hit test
  logic [SPRITE_COUNT-1:0] w_spr_hit;
  logic [TAW-1:0]          w_spr_addr [SPRITE_COUNT];

  for (genvar g = 0; g < SPRITE_COUNT; g++) begin : g_spr
    logic [CW1-1:0] w_sx, w_sy, w_px, w_py;
    logic [SB-1:0]  w_dx, w_dy;
    assign w_sx = {1'b0, r_act_x[g]};
    assign w_sy = {1'b0, r_act_y[g]};
    assign w_px = {1'b0, x};
    assign w_py = {1'b0, y};
    // Only the low SB bits of the offset matter inside the sprite.
    assign w_dx = x[SB-1:0] - r_act_x[g][SB-1:0];
    assign w_dy = y[SB-1:0] - r_act_y[g][SB-1:0];
    // One extra bit keeps sx+SPRITE_SIZE from wrapping past the coordinate limit.
    assign w_spr_hit[g] = r_act_en[g] && (int'(r_act_tex[g]) < TEXTURE_COUNT) &&
                          (w_px >= w_sx) && (w_px < w_sx + CW1'(SPRITE_SIZE)) &&
                          (w_py >= w_sy) && (w_py < w_sy + CW1'(SPRITE_SIZE));
    assign w_spr_addr[g] = (TAW'(r_act_tex[g]) << (2 * SB)) | (TAW'(w_dy) << SB) | TAW'(w_dx);
  end

  logic           w_hit, w_pix_hit;
  logic [TAW-1:0] w_hit_addr;

  // Scanning from the highest index down lets the lowest-index hit win.
  always_comb begin
    w_hit      = 1'b0;
    w_hit_addr = '0;
    for (int i = SPRITE_COUNT - 1; i >= 0; i--) begin
      if (w_spr_hit[i]) begin
        w_hit      = 1'b1;
        w_hit_addr = w_spr_addr[i];
      end
    end
    w_pix_hit = w_hit && visible;
  end

  assign raddr = w_pix_hit ? w_hit_addr : '0;

  logic r_s1_pix, r_s1_hit, r_s1_vis, r_s1_hs, r_s1_vs;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_s1_pix <= 1'b0;
      r_s1_hit <= 1'b0;
      r_s1_vis <= 1'b0;
      r_s1_hs  <= 1'b1;
      r_s1_vs  <= 1'b1;
    end else begin
      r_s1_pix <= pix_en;
      r_s1_hit <= w_pix_hit;
      r_s1_vis <= visible;
      r_s1_hs  <= hsync_in;
      r_s1_vs  <= vsync_in;
    end
  end

  // ------------------------------------------------------- stage 2: colour
  logic [COLOR_WIDTH-1:0] w_color, r_rgb;
  logic                   r_hsync, r_vsync;

  assign w_color = (r_s1_hit && rtexel != TRANSPARENT) ? rtexel :
                   r_s1_vis ? r_act_bg : '0;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_rgb   <= '0;
      r_hsync <= 1'b1;
      r_vsync <= 1'b1;
    end else if (r_s1_pix) begin
      r_rgb   <= w_color;
      r_hsync <= r_s1_hs;
      r_vsync <= r_s1_vs;
    end
  end

  assign red   = r_rgb[11:8];
  assign green = r_rgb[7:4];
  assign blue  = r_rgb[3:0];
  assign hsync = r_hsync;
  assign vsync = r_vsync;

endmodule

// File: tb/tb_sprite_compositor.sv
// Self-checking bench for sprite_compositor. Pixel vectors come from a table;
// expected colour/sync values are queued when a pixel is driven and compared
// when the delayed pixel strobe says the DUT output is due. AXI corner cases
// and the commit/write collision are hand-written sequences.
module tb_sprite_compositor;

  logic        clk = 1'b0;
  logic        rst;
  logic [23:0] awaddr;
  logic [2:0]  awprot;
  logic        awvalid, awready;
  logic [31:0] wdata;
  logic [3:0]  wstrb;
  logic        wvalid, wready;
  logic [1:0]  bresp;
  logic        bvalid, bready;
  logic        pix_en;
  logic [9:0]  x, y;
  logic        visible, hsync_in, vsync_in;
  logic [13:0] raddr;
  logic [11:0] rtexel;
  logic [3:0]  red, green, blue;
  logic        hsync, vsync;

  sprite_compositor dut (
    .clk(clk), .rst(rst),
    .awaddr(awaddr), .awprot(awprot), .awvalid(awvalid), .awready(awready),
    .wdata(wdata), .wstrb(wstrb), .wvalid(wvalid), .wready(wready),
    .bresp(bresp), .bvalid(bvalid), .bready(bready),
    .pix_en(pix_en), .x(x), .y(y), .visible(visible),
    .hsync_in(hsync_in), .vsync_in(vsync_in),
    .raddr(raddr), .rtexel(rtexel),
    .red(red), .green(green), .blue(blue), .hsync(hsync), .vsync(vsync)
  );

  always #5 clk = ~clk;

  // Texture RAM model: synchronous read, one cycle latency.
  logic [11:0] tex_mem [16384];
  initial rtexel = 12'h000;
  always @(posedge clk) rtexel <= tex_mem[raddr];

  int n_tests = 0;
  int n_fail  = 0;

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", nm, act, exp);
    end
  endtask

  // ------------------------------------------------------------ scoreboard
  typedef struct {
    int          id;
    logic [11:0] rgb;
    logic        hs;
    logic        vs;
  } exp_t;
  exp_t sb[$];

  logic [1:0] pipe = 2'b00;
  always @(posedge clk) pipe <= {pipe[0], pix_en};

  always @(negedge clk) begin
    if (pipe[1]) begin
      if (sb.size() == 0) begin
        check("sb_underflow", 32'd1, 32'd0);
      end else begin
        exp_t e;
        e = sb.pop_front();
        check($sformatf("pix%0d_rgb", e.id), {20'd0, red, green, blue}, {20'd0, e.rgb});
        check($sformatf("pix%0d_hs", e.id), {31'd0, hsync}, {31'd0, e.hs});
        check($sformatf("pix%0d_vs", e.id), {31'd0, vsync}, {31'd0, e.vs});
      end
    end
  end

  // ------------------------------------------------------------ pixel table
  typedef struct {
    int          phase;
    int          px;
    int          py;
    logic        vis;
    logic        hs;
    logic        vs;
    int          exp_addr;  // -1: no sprite hit
    logic [11:0] bg;
  } pix_vec_t;
  pix_vec_t vecs[$];

  task automatic drive_vec(input int id, input pix_vec_t v);
    logic [11:0] t;
    exp_t        e;
    pix_en   = 1'b1;
    x        = 10'(v.px);
    y        = 10'(v.py);
    visible  = v.vis;
    hsync_in = v.hs;
    vsync_in = v.vs;
    #1;
    e.id = id;
    e.hs = v.hs;
    e.vs = v.vs;
    if (v.exp_addr >= 0) begin
      check($sformatf("pix%0d_raddr", id), {18'd0, raddr}, v.exp_addr);
      t = tex_mem[v.exp_addr];
      e.rgb = (t != 12'hF0F) ? t : (v.vis ? v.bg : 12'h000);
    end else begin
      check($sformatf("pix%0d_raddr", id), {18'd0, raddr}, 32'd0);
      e.rgb = v.vis ? v.bg : 12'h000;
    end
    sb.push_back(e);
    @(negedge clk);
  endtask

  task automatic run_phase(input int p);
    foreach (vecs[i]) if (vecs[i].phase == p) drive_vec(i, vecs[i]);
    pix_en   = 1'b0;
    visible  = 1'b0;
    hsync_in = 1'b1;
    vsync_in = 1'b1;
    repeat (4) @(negedge clk);
    check($sformatf("drain_phase%0d", p), sb.size(), 0);
  endtask

  task automatic vsync_pulse();
    vsync_in = 1'b0;
    @(negedge clk);
    vsync_in = 1'b1;
    repeat (2) @(negedge clk);
  endtask

  // ------------------------------------------------------------ AXI helpers
  task automatic send_aw(input logic [23:0] a);
    int n = 0;
    awaddr  = a;
    awvalid = 1'b1;
    while (!awready && n < 40) begin @(negedge clk); n++; end
    if (!awready) check("aw_timeout", 32'd1, 32'd0);
    @(posedge clk);
    @(negedge clk);
    awvalid = 1'b0;
  endtask

  task automatic send_w(input logic [31:0] d, input logic [3:0] s);
    int n = 0;
    wdata  = d;
    wstrb  = s;
    wvalid = 1'b1;
    while (!wready && n < 40) begin @(negedge clk); n++; end
    if (!wready) check("w_timeout", 32'd1, 32'd0);
    @(posedge clk);
    @(negedge clk);
    wvalid = 1'b0;
  endtask

  task automatic axi_write(input string nm, input logic [23:0] a, input logic [31:0] d,
                           input logic [3:0] s, input int aw_dly, input int w_dly,
                           input int hold, input logic [1:0] exp_resp);
    int n = 0;
    bready = 1'b0;
    fork
      begin repeat (aw_dly) @(negedge clk); send_aw(a); end
      begin repeat (w_dly) @(negedge clk); send_w(d, s); end
    join
    while (!bvalid && n < 40) begin @(negedge clk); n++; end
    check({nm, "_b_latency"}, n, 1);
    for (int i = 0; i < hold; i++) begin
      check($sformatf("%s_hold%0d_bvalid", nm, i), {31'd0, bvalid}, 32'd1);
      check($sformatf("%s_hold%0d_awready", nm, i), {31'd0, awready}, 32'd0);
      @(negedge clk);
    end
    check({nm, "_bresp"}, {30'd0, bresp}, {30'd0, exp_resp});
    bready = 1'b1;
    @(negedge clk);
    bready = 1'b0;
    check({nm, "_b_done"}, {31'd0, bvalid}, 32'd0);
  endtask

  // ------------------------------------------------------------ watchdog
  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish, got timeout, expected completion");
    $fatal(1, "watchdog expired");
  end

  // ------------------------------------------------------------ main
  initial begin
    for (int i = 0; i < 16384; i++) tex_mem[i] = 12'(i * 37 + 5);
    tex_mem[4097] = 12'hF0F;  // sprite 0, pixel (1,0): transparent
    tex_mem[4098] = 12'h123;  // sprite 0, pixel (2,0)

    //            phase  x     y   vis hs  vs  addr   bg
    vecs.push_back('{0,   10,   10, 1, 1, 1,   -1, 12'h000});
    vecs.push_back('{0,  100,  100, 1, 0, 1,   -1, 12'h000});
    vecs.push_back('{0,    5,    5, 0, 1, 1,   -1, 12'h000});
    vecs.push_back('{1,  100,  100, 1, 1, 1,   -1, 12'h000});
    vecs.push_back('{1,  164,  100, 1, 1, 1,   -1, 12'h000});
    vecs.push_back('{2,  100,  100, 1, 1, 1, 4096, 12'h0A5});
    vecs.push_back('{2,  164,  100, 1, 0, 1,   -1, 12'h0A5});
    vecs.push_back('{2,  163,  163, 1, 0, 0, 8191, 12'h0A5});
    vecs.push_back('{2,  120,  110, 1, 1, 1, 4756, 12'h0A5});
    vecs.push_back('{2,   99,  100, 1, 1, 1,   -1, 12'h0A5});
    vecs.push_back('{2,  100,  164, 1, 1, 1,   -1, 12'h0A5});
    vecs.push_back('{2,  100,  100, 0, 1, 1,   -1, 12'h0A5});
    vecs.push_back('{3,  101,  100, 1, 1, 1, 4097, 12'h0A5});
    vecs.push_back('{3,  102,  100, 1, 1, 1, 4098, 12'h0A5});
    vecs.push_back('{3,   95,  100, 1, 0, 1, 8197, 12'h0A5});
    vecs.push_back('{3,  160,  100, 1, 1, 1, 4156, 12'h0A5});
    vecs.push_back('{3,   89,  100, 1, 1, 0,   -1, 12'h0A5});
    vecs.push_back('{4,  100,  100, 1, 1, 1, 4096, 12'h0A5});
    vecs.push_back('{4,  200,  100, 1, 1, 1,   -1, 12'h0A5});
    vecs.push_back('{5,  100,  100, 1, 1, 1, 8202, 12'h0A5});
    vecs.push_back('{5,  200,  100, 1, 1, 1, 4096, 12'h0A5});
    vecs.push_back('{5,  263,  163, 1, 1, 1, 8191, 12'h0A5});
    vecs.push_back('{5,  264,  100, 1, 1, 1,   -1, 12'h0A5});
    vecs.push_back('{6,  200,  100, 1, 1, 1, 4096, 12'h0A5});
    vecs.push_back('{6,  300,  100, 1, 1, 1,   -1, 12'h0A5});
    vecs.push_back('{7,  300,  100, 1, 1, 1, 4096, 12'h0A5});
    vecs.push_back('{7,  200,  100, 1, 1, 1,   -1, 12'h0A5});
    vecs.push_back('{8, 1023,  100, 1, 1, 1,   23, 12'h0FF});
    vecs.push_back('{8, 1000,  163, 1, 0, 1, 4032, 12'h0FF});
    vecs.push_back('{8,    5,  100, 1, 1, 1,   -1, 12'h0FF});
    vecs.push_back('{8,    5,    5, 1, 1, 1,   -1, 12'h0FF});
    vecs.push_back('{8, 1023,   99, 1, 1, 1,   -1, 12'h0FF});

    rst = 1'b0;
    awaddr = '0; awprot = '0; awvalid = 1'b0;
    wdata = '0; wstrb = '0; wvalid = 1'b0; bready = 1'b0;
    pix_en = 1'b0; x = '0; y = '0; visible = 1'b0;
    hsync_in = 1'b1; vsync_in = 1'b1;

    // Reset state
    repeat (3) @(negedge clk);
    check("rst_awready", {31'd0, awready}, 32'd0);
    check("rst_wready", {31'd0, wready}, 32'd0);
    check("rst_bvalid", {31'd0, bvalid}, 32'd0);
    check("rst_bresp", {30'd0, bresp}, 32'd0);
    check("rst_raddr", {18'd0, raddr}, 32'd0);
    check("rst_rgb", {20'd0, red, green, blue}, 32'd0);
    check("rst_hsync", {31'd0, hsync}, 32'd1);
    check("rst_vsync", {31'd0, vsync}, 32'd1);
    rst = 1'b1;
    @(negedge clk);
    check("post_rst_awready", {31'd0, awready}, 32'd1);
    check("post_rst_wready", {31'd0, wready}, 32'd1);

    run_phase(0);  // solid black, nothing enabled

    // Single sprite
    axi_write("bg",    24'h40, 32'h0000_00A5, 4'hF, 0, 0, 0, 2'b00);
    axi_write("s0pos", 24'h00, 32'h0064_0064, 4'hF, 0, 0, 0, 2'b00);
    axi_write("s0ctl", 24'h04, 32'h8000_0001, 4'hF, 0, 0, 0, 2'b00);
    run_phase(1);  // not yet committed
    vsync_pulse();
    run_phase(2);

    // Priority and transparency: sprite 1 overlaps sprite 0
    axi_write("s1pos", 24'h08, 32'h0064_005A, 4'hF, 0, 0, 0, 2'b00);
    axi_write("s1ctl", 24'h0C, 32'h8000_0002, 4'hF, 0, 0, 0, 2'b00);
    vsync_pulse();
    run_phase(3);

    // Mid-frame move stays invisible until vsync
    axi_write("s0mov", 24'h00, 32'h0064_00C8, 4'hF, 0, 0, 0, 2'b00);
    run_phase(4);
    vsync_pulse();
    run_phase(5);

    // Write landing on the commit edge takes effect one frame later
    check("coin_awready", {31'd0, awready}, 32'd1);
    check("coin_wready", {31'd0, wready}, 32'd1);
    awaddr = 24'h00; awvalid = 1'b1;
    wdata = 32'h0064_012C; wstrb = 4'hF; wvalid = 1'b1;
    @(posedge clk);  // both handshakes
    @(negedge clk);
    awvalid = 1'b0; wvalid = 1'b0;
    vsync_in = 1'b0;
    @(posedge clk);  // shadow write and commit on the same edge
    @(negedge clk);
    vsync_in = 1'b1;
    check("coin_bvalid", {31'd0, bvalid}, 32'd1);
    check("coin_bresp", {30'd0, bresp}, 32'd0);
    bready = 1'b1;
    @(negedge clk);
    bready = 1'b0;
    check("coin_b_done", {31'd0, bvalid}, 32'd0);
    repeat (2) @(negedge clk);
    run_phase(6);
    vsync_pulse();
    run_phase(7);

    // AXI corner cases
    axi_write("w_first", 24'h14, 32'h8000_0004, 4'hF, 3, 0, 0, 2'b00);  // tex 4 invalid
    check("w_first_single_resp", {31'd0, bvalid}, 32'd0);
    axi_write("s3pos_hold", 24'h18, 32'h0064_03E8, 4'hF, 0, 0, 5, 2'b00);
    axi_write("s3ctl", 24'h1C, 32'h8000_0000, 4'hF, 0, 0, 0, 2'b00);
    axi_write("bg_strb", 24'h40, 32'h0000_0FFF, 4'h1, 0, 0, 0, 2'b00);
    axi_write("bg_nostrb", 24'h40, 32'h0000_0000, 4'h0, 0, 0, 0, 2'b00);
    axi_write("slverr_100", 24'h100, 32'hFFFF_FFFF, 4'hF, 0, 0, 0, 2'b10);
    axi_write("slverr_44", 24'h44, 32'hFFFF_FFFF, 4'hF, 0, 0, 0, 2'b10);
    vsync_pulse();
    run_phase(8);  // clipping, invalid texture, strobed background

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
